// File: rtl/sp_sync_ram_large.sv
// Single-port synchronous RAM built from four equal banks that share one
// bidirectional data bus. The two address MSBs select the bank. Reads are
// captured into a per-bank read register, and the bank index is registered on
// the same edge so the output mux follows the captured read.
module sp_sync_ram_large #(
    parameter int unsigned ADDR_WIDTH = 18,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr,
    inout  wire  [DATA_WIDTH-1:0] data,
    input  logic                  cs_input,
    input  logic                  we,
    input  logic                  oe
);

    localparam int unsigned NumBanks   = 4;
    localparam int unsigned OffWidth   = ADDR_WIDTH - 2;
    localparam int unsigned BankDepth  = 1 << OffWidth;

    logic [1:0]            bank_sel;
    logic [OffWidth-1:0]   offset;
    logic [NumBanks-1:0]   bank_wr;
    logic [NumBanks-1:0]   bank_rd;
    logic [1:0]            bank_q;
    logic [DATA_WIDTH-1:0] bank_rdata [NumBanks];
    logic [DATA_WIDTH-1:0] rdata;
    logic                  drive_en;

    assign bank_sel = addr[ADDR_WIDTH-1:ADDR_WIDTH-2];
    assign offset   = addr[OffWidth-1:0];

    // One-hot bank enables split into write and read strobes
    always_comb begin
        bank_wr = '0;
        bank_rd = '0;
        if (cs_input) begin
            unique case (bank_sel)
                2'd0:    begin bank_wr[0] = we; bank_rd[0] = ~we; end
                2'd1:    begin bank_wr[1] = we; bank_rd[1] = ~we; end
                2'd2:    begin bank_wr[2] = we; bank_rd[2] = ~we; end
                default: begin bank_wr[3] = we; bank_rd[3] = ~we; end
            endcase
        end
    end

    for (genvar k = 0; k < NumBanks; k++) begin : g_bank
        logic [DATA_WIDTH-1:0] mem [BankDepth];
        logic [DATA_WIDTH-1:0] rdata_q;

        // Array write and read capture; reset clears only the read register,
        // and a write edge during reset falls into the reset branch and is lost
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                rdata_q <= '0;
            end else begin
                if (bank_wr[k]) begin
                    mem[offset] <= data;
                end
                if (bank_rd[k]) begin
                    rdata_q <= mem[offset];
                end
            end
        end

        assign bank_rdata[k] = rdata_q;
    end

    // Bank index of the most recent read, steering the output mux
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= 2'd0;
        end else if (cs_input && !we) begin
            bank_q <= bank_sel;
        end
    end

    // Output mux from the captured bank and a bus driver that follows the live pins
    always_comb begin
        rdata    = bank_rdata[bank_q];
        drive_en = cs_input & oe & ~we;
    end

    assign data = drive_en ? rdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_sp_sync_ram_large.sv
// Directed bench for sp_sync_ram_large. The bus carries a pull-up, so an
// undriven bus reads as all ones; checks that expect high-Z use 16'hFFFF and
// are only made while the read register holds some other value.
module tb_sp_sync_ram_large;

    logic        clk;
    logic        rst_n;
    logic [17:0] addr;
    logic        cs_input;
    logic        we;
    logic        oe;
    logic [15:0] drv;
    logic        tb_en;
    tri1  [15:0] data;

    int tests;
    int fails;

    logic [17:0] baddr [16];
    logic [15:0] bval  [16];

    assign data = tb_en ? drv : 16'hzzzz;

    sp_sync_ram_large #(
        .ADDR_WIDTH(18),
        .DATA_WIDTH(16)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .data     (data),
        .cs_input (cs_input),
        .we       (we),
        .oe       (oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] exp);
        tests++;
        assert (data === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, data, exp);
        end
    endtask

    task automatic do_write(input logic [17:0] a, input logic [15:0] v);
        addr     = a;
        drv      = v;
        tb_en    = 1'b1;
        cs_input = 1'b1;
        we       = 1'b1;
        oe       = 1'b0;
        step();
        tb_en    = 1'b0;
    endtask

    task automatic set_read(input logic [17:0] a);
        tb_en    = 1'b0;
        addr     = a;
        cs_input = 1'b1;
        we       = 1'b0;
        oe       = 1'b1;
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        cs_input = 1'b1;
        we       = 1'b0;
        oe       = 1'b1;
        addr     = '0;
        drv      = '0;
        tb_en    = 1'b0;

        // Reset: bus driven with the cleared read register
        #3;
        check("reset_hold", 16'h0000);
        step();
        rst_n = 1'b1;
        #1;
        check("reset_release", 16'h0000);

        // Bank-boundary writes, one per cycle
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                baddr[k*4+j] = {k[1:0], 16'hFFFC} + 18'(j);
                bval[k*4+j]  = 16'h1000 * 16'(k + 1) + 16'h0101 * 16'(j) + 16'h0023;
            end
        end
        for (int i = 0; i < 16; i++) begin
            do_write(baddr[i], bval[i]);
        end

        // Back-to-back reads; data for each address one cycle after it is applied
        for (int i = 0; i < 16; i++) begin
            set_read(baddr[i]);
            step();
            check($sformatf("boundary_rd_%05h", baddr[i]), bval[i]);
        end

        // Bank isolation
        do_write(18'h00010, 16'hAAAA);
        do_write(18'h10010, 16'h5555);
        do_write(18'h20010, 16'h2222);
        do_write(18'h30010, 16'h3333);
        set_read(18'h00010);
        step();
        check("isolation_rd", 16'hAAAA);

        // Bus control, all between edges
        oe = 1'b0;
        #1;
        check("bus_oe_low", 16'hFFFF);
        oe = 1'b1;
        we = 1'b1;
        #1;
        check("bus_we_high", 16'hFFFF);
        we = 1'b0;
        cs_input = 1'b0;
        #1;
        check("bus_cs_low", 16'hFFFF);
        cs_input = 1'b1;
        #1;
        check("bus_redriven", 16'hAAAA);

        // Write with reset asserted must be dropped
        rst_n = 1'b0;
        do_write(18'h00010, 16'h0BAD);
        rst_n = 1'b1;
        set_read(18'h00010);
        step();
        check("reset_write_suppressed", 16'hAAAA);

        // Chip-select-gated write
        do_write(18'h12345, 16'h1234);
        addr     = 18'h12345;
        drv      = 16'hBEEF;
        tb_en    = 1'b1;
        cs_input = 1'b0;
        we       = 1'b1;
        oe       = 1'b0;
        step();
        set_read(18'h12345);
        step();
        check("cs_gated_write", 16'h1234);

        // Reset mid-read
        do_write(18'h3FFFF, 16'h7E57);
        set_read(18'h3FFFF);
        step();
        check("pre_reset_rd", 16'h7E57);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_read_reset", 16'h0000);
        #1;
        rst_n = 1'b1;
        step();
        check("post_reset_rd", 16'h7E57);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/sp_sync_ram_large.md
# sp_sync_ram_large

Single-port synchronous RAM of 2^ADDR_WIDTH words × DATA_WIDTH bits (default 256K × 16). It is built from four equal banks selected by the two address MSBs, and it has one shared bidirectional data bus. It serves as the large backing memory of the design and is accessed by a controller that drives the bus only when `oe` is low.

## Interface
Parameters:
- `ADDR_WIDTH`, default 18: word address width. Must be ≥ 3.
- `DATA_WIDTH`, default 16: word width.
- Each bank holds 2^(ADDR_WIDTH-2) words.

Ports:
- `clk`, in, 1: the single clock. All state changes on its rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `addr`, in, ADDR_WIDTH: word address. `addr[ADDR_WIDTH-1:ADDR_WIDTH-2]` selects the bank; the remaining bits are the in-bank offset.
- `data`, inout, DATA_WIDTH: shared bus. It carries write data in and read data out. The RAM drives it only while `cs_input & oe & ~we`; otherwise it is high-Z.
- `cs_input`, in, 1: chip select, active-high.
- `we`, in, 1: write enable, active-high. 1 = write, 0 = read.
- `oe`, in, 1: output enable, active-high. It gates only the bus driver.

## Operation
- **Bank decode:**
  - Bank k (k = 0..3) is the only enabled bank when `cs_input=1` and `addr[MSB:MSB-1]=k`.
  - Bank 0 covers 0x00000–0x0FFFF, bank 1 covers 0x10000–0x1FFFF, bank 2 covers 0x20000–0x2FFFF, and bank 3 covers 0x30000–0x3FFFF (default widths).
- **Write:**
  - At a rising edge with `cs_input=1, we=1`, the selected bank stores `data` at the in-bank offset.
  - `oe` is ignored for writes.
  - No other bank changes.
- **Read:**
  - At a rising edge with `cs_input=1, we=0`, the selected bank's word is loaded into a read-data register.
  - The bank index is registered in the same edge, and the output mux uses that registered bank index.
- **Idle:** when `cs_input=0`, no write occurs, the read register holds, and the bus is high-Z.
- **Bus driver:**
  - `data` = read register when `cs_input & oe & ~we`; otherwise Z.
  - The driver enable is combinational from the current pins.
- **Memory contents:**
  - Contents are undefined at power-up. Simulation returns X for never-written words.
  - Reset does not clear the memory array.
- **Reset:**
  - `rst_n=0` asynchronously clears the read-data register to 0 and the registered bank index to 0.
  - A write edge coincident with asserted reset is suppressed.
  - Reset does not force the bus to Z; the bus driver stays a function of `cs_input`, `oe` and `we`.

## Timing
- **Write latency:** 1 edge. The word is readable by a read issued at the next edge.
- **Read latency:** the address presented before edge N is captured at edge N. `data` shows mem[addr] after edge N for as long as the read pins stay asserted.
  - Under stimulus that updates pins just after each edge, data for address A appears one cycle after A is applied.
- **Back-to-back operation:** one access per cycle, with no bubbles for write→read, read→write or bank switching.
- **Read then write:** the read register keeps its last value through the write. The bus is Z while `we=1`.
- **Out-of-range addresses:** none are possible; every address maps to exactly one bank.
- **Address wrap:** address wrap is not applicable because each access is independent.

## Test plan
- **Reset:**
  - Stimulus: `rst_n=0`, then release it with `cs_input=1, we=0, oe=1`.
  - Required response: `data` reads 0x0000 until the first read edge.
- **Bank-boundary writes and reads:**
  - Stimulus: write random values to 0x0FFFC–0x0FFFF, 0x1FFFC–0x1FFFF, 0x2FFFC–0x2FFFF and 0x3FFFC–0x3FFFF, one per cycle. Then read the same 16 addresses back-to-back.
  - Required response: each read returns its written value one cycle after its address is applied.
- **Bank isolation:**
  - Stimulus: write 0xAAAA to 0x00010, then 0x5555 to 0x10010, 0x2222 to 0x20010 and 0x3333 to 0x30010.
  - Required response: reading 0x00010 still returns 0xAAAA.
- **Bus control:**
  - Stimulus: during a read, drop `oe`, then raise `we`, then drop `cs_input`.
  - Required response: `data` is Z in each case, and is driven again when `cs_input=1, oe=1, we=0`.
- **Chip-select-gated write:**
  - Stimulus: attempt a write to 0x12345 with `cs_input=0`, bus value 0xBEEF, over a location that holds 0x1234.
  - Required response: a later read of 0x12345 still returns 0x1234.
- **Reset mid-read:**
  - Stimulus: assert `rst_n=0` between edges while reading 0x3FFFF (holds 0x7E57).
  - Required response: `data` immediately shows 0x0000. After release, the next read edge restores 0x7E57, since contents are preserved.
